// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet tap line, the wavelet filter datapath and
// the shift-line sequencer: default geometry and the sequencer state encoding.
package wavelet_pkg;

  localparam int DEFAULT_TOTAL_TAPS   = 9;
  localparam int DEFAULT_BITS_PER_TAP = 8;
  localparam int DEFAULT_DIV_WIDTH    = 25;
  localparam int DEFAULT_FILL_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_TICK   = 2'd1,
    WAIT_SAMPLE = 2'd2,
    COMPUTE     = 2'd3
  } seq_state_e;

  // Increment that sticks at the limit; used for the tap fill level.
  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

  // Where the sequencer goes once it is released (window done or flush):
  // keep running if still enabled, otherwise park.
  function automatic seq_state_e resume_state(input logic enable);
    return enable ? WAIT_TICK : IDLE;
  endfunction

endpackage

// File: rtl/shift_line_sequencer_if.sv
// Handshake bundle between the shift-line sequencer and its neighbours:
// sample source (valid/ready), tap line (shift enable) and filter (start/done).
// master = sequencer side, slave = environment side.
interface shift_line_sequencer_if;

  logic i_value_valid;
  logic o_value_ready;
  logic o_shift_en;
  logic o_compute_start;
  logic i_compute_done;

  modport master (
    input  i_value_valid,
    input  i_compute_done,
    output o_value_ready,
    output o_shift_en,
    output o_compute_start
  );

  modport slave (
    output i_value_valid,
    output i_compute_done,
    input  o_value_ready,
    input  o_shift_en,
    input  o_compute_start
  );

endinterface

// File: rtl/shift_line_sequencer_tick_gen.sv
// Sample-rate tick generator: reload-on-zero down-counter.
// The counter is parked at zero while hold_i is high so the first cycle after
// release ticks immediately; clear_i forces the same restart point.
// The divisor is only looked at on reload, so it may change freely between ticks.
module sample_tick_gen
  import wavelet_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold_i,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  // Next count and tick: parked/cleared -> zero, terminal count -> tick + reload.
  always_comb begin
    count_d = count_q;
    tick_o  = 1'b0;
    if (hold_i || clear_i) begin
      count_d = '0;
    end else if (count_q == '0) begin
      tick_o  = 1'b1;
      count_d = divisor_i;
    end else begin
      count_d = count_q - DIV_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_line_sequencer.sv
// Shift-line sequencer: paces sample intake with a programmable tick, shifts
// accepted samples into the tap line, tracks the fill level and hands every
// full window to the wavelet filter.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | parked; tick counter held at zero, no intake
//   WAIT_TICK   | running, waiting for the next sample-rate tick
//   WAIT_SAMPLE | tick seen, ready for one sample from the source
//   COMPUTE     | window full, filter owns it until compute_done
//
// Ticks arriving in WAIT_SAMPLE or COMPUTE are dropped and flagged as overrun
// (sticky until reset or flush). Once the line is full it stays full, so every
// later accepted sample immediately starts a new (sliding) window.
module shift_line_sequencer
  import wavelet_pkg::*;
#(
  parameter int TOTAL_TAPS   = DEFAULT_TOTAL_TAPS,
  parameter int BITS_PER_TAP = DEFAULT_BITS_PER_TAP,
  parameter int DIV_WIDTH    = DEFAULT_DIV_WIDTH,
  parameter int FILL_WIDTH   = DEFAULT_FILL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [DIV_WIDTH-1:0]  i_divisor,
  shift_line_sequencer_if.master hs,
  output logic                  o_taps_valid,
  output logic [FILL_WIDTH-1:0] o_fill_count,
  output logic                  o_overrun,
  output logic                  o_LED
);

  // The fill counter must be able to represent a full window, and the tap
  // geometry must be meaningful for the line this block drives.
  if (TOTAL_TAPS < 1 || BITS_PER_TAP < 1 || (2 ** FILL_WIDTH) <= TOTAL_TAPS) begin : g_bad_config
    $error("shift_line_sequencer: FILL_WIDTH too narrow for TOTAL_TAPS or bad tap geometry");
  end

  localparam logic [FILL_WIDTH-1:0] FULL_COUNT = FILL_WIDTH'(TOTAL_TAPS);

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [FILL_WIDTH-1:0] fill_q;
  logic [FILL_WIDTH-1:0] fill_d;
  logic [FILL_WIDTH-1:0] fill_inc;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  led_q;
  logic                  led_d;
  logic                  first_q;
  logic                  first_d;

  logic                  tick;
  logic                  value_ready;
  logic                  accept;
  logic                  compute_start;

  sample_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (state_q == IDLE),
    .clear_i   (i_flush),
    .divisor_i (i_divisor),
    .tick_o    (tick)
  );

  assign fill_inc = FILL_WIDTH'(sat_inc(int'(fill_q), TOTAL_TAPS));

  // Next state, fill/overrun/heartbeat update and handshake outputs.
  // Flush is applied last so it overrides every other update.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    overrun_d     = overrun_q;
    first_d       = 1'b0;
    led_d         = led_q ^ tick;
    value_ready   = 1'b0;
    accept        = 1'b0;
    compute_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = WAIT_SAMPLE;
        end
      end

      WAIT_SAMPLE: begin
        value_ready = !i_flush;
        accept      = value_ready && hs.i_value_valid;
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (accept) begin
          fill_d = fill_inc;
          if (fill_inc == FULL_COUNT) begin
            state_d = COMPUTE;
            first_d = 1'b1;
          end else begin
            state_d = WAIT_TICK;
          end
        end else if (!i_enable) begin
          state_d = IDLE;
        end
      end

      COMPUTE: begin
        // Disable is deferred: the filter keeps the window until it reports done.
        compute_start = first_q;
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (hs.i_compute_done) begin
          state_d = resume_state(i_enable);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_flush) begin
      state_d   = resume_state(i_enable);
      fill_d    = '0;
      overrun_d = 1'b0;
      first_d   = 1'b0;
    end
  end

  // State, fill, overrun, heartbeat and window-start registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      overrun_q <= 1'b0;
      led_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
      first_q   <= first_d;
    end
  end

  assign hs.o_value_ready   = value_ready;
  assign hs.o_shift_en      = accept;
  assign hs.o_compute_start = compute_start;
  assign o_taps_valid       = (fill_q == FULL_COUNT);
  assign o_fill_count       = fill_q;
  assign o_overrun          = overrun_q;
  assign o_LED              = led_q;

endmodule
